// File: rtl/adc_avg_pkg.sv
// Shared types and sizing helpers for the windowed ADC averaging filter.
package adc_avg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DUMP
    } state_t;

    localparam int DATA_W_DEF = 12;

    // Accumulator holds N full-scale samples plus the rounding half-LSB without overflow.
    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/adc_avg_chan.sv
// One channel of the averaging filter: accumulator, window min/max and rounded mean.
module adc_avg_chan
    import adc_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_first,
    input  logic              accumulate,
    input  logic              clear,
    input  logic              dump,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val
);

    localparam int ACC_W  = acc_width(DATA_W, LOG2_N);
    localparam int RND_SH = (LOG2_N > 0) ? LOG2_N - 1 : 0;
    localparam logic [ACC_W-1:0] RND = (LOG2_N > 0) ? (ACC_W'(1) << RND_SH) : '0;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  rounded;
    logic [DATA_W-1:0] avg_d;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_max;

    always_comb begin
        rounded = acc + RND;
        avg_d   = DATA_W'(rounded >> LOG2_N);
    end

    // dump reads the finished window while load_first may already start the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            win_min <= '0;
            win_max <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load_first) begin
            acc     <= ACC_W'(sample);
            win_min <= sample;
            win_max <= sample;
        end else if (accumulate) begin
            acc <= acc + ACC_W'(sample);
            if (sample < win_min) win_min <= sample;
            if (sample > win_max) win_max <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg     <= '0;
            min_val <= '0;
            max_val <= '0;
        end else if (dump) begin
            avg     <= avg_d;
            min_val <= win_min;
            max_val <= win_max;
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Dual-channel windowed mean and min/max filter fed by spi_adc sample strobes.
module adc_avg_filter
    import adc_avg_pkg::*;
#(
    parameter int LOG2_N = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic              avg_valid_o,
    output logic [DATA_W-1:0] avg0_o,
    output logic [DATA_W-1:0] avg1_o,
    output logic [DATA_W-1:0] min0_o,
    output logic [DATA_W-1:0] max0_o,
    output logic [DATA_W-1:0] min1_o,
    output logic [DATA_W-1:0] max1_o
);

    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] N_CNT = CW'(1) << LOG2_N;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] cnt_inc;
    logic          load_first, accumulate, clr, dump;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            avg_valid_o <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            avg_valid_o <= dump;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        load_first = 1'b0;
        accumulate = 1'b0;
        clr        = 1'b0;
        dump       = 1'b0;
        cnt_inc    = cnt + CW'(1);
        if (!en_i) begin
            state_n = IDLE;
            cnt_n   = '0;
            clr     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clr     = 1'b1;
                    cnt_n   = '0;
                    state_n = ACCUM;
                end
                ACCUM: begin
                    if (clear_i) begin
                        clr   = 1'b1;
                        cnt_n = '0;
                    end else if (sample_valid_i) begin
                        load_first = (cnt == '0);
                        accumulate = (cnt != '0);
                        cnt_n      = cnt_inc;
                        if (cnt_inc == N_CNT) state_n = DUMP;
                    end
                end
                DUMP: begin
                    // A strobe here opens the next window; with N=1 it also closes it.
                    dump    = 1'b1;
                    state_n = ACCUM;
                    cnt_n   = '0;
                    if (clear_i || !sample_valid_i) begin
                        clr = 1'b1;
                    end else begin
                        load_first = 1'b1;
                        cnt_n      = CW'(1);
                        if (N_CNT == CW'(1)) state_n = DUMP;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    adc_avg_chan #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_chan0 (
        .clk        (clk),
        .rst        (rst),
        .load_first (load_first),
        .accumulate (accumulate),
        .clear      (clr),
        .dump       (dump),
        .sample     (data0_i),
        .avg        (avg0_o),
        .min_val    (min0_o),
        .max_val    (max0_o)
    );

    adc_avg_chan #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_chan1 (
        .clk        (clk),
        .rst        (rst),
        .load_first (load_first),
        .accumulate (accumulate),
        .clear      (clr),
        .dump       (dump),
        .sample     (data1_i),
        .avg        (avg1_o),
        .min_val    (min1_o),
        .max_val    (max1_o)
    );

endmodule
